// File: rtl/mem_access_sequencer_if.sv
// Data-memory port bundle between the MEM-stage access sequencer (master)
// and the data memory (slave).
interface mem_access_sequencer_if;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic [1:0]  mem_byte_enable;
   logic        mem_resp;
   logic [15:0] mem_rdata;

   modport master (
      output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      input  mem_resp, mem_rdata
   );

   modport slave (
      input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      output mem_resp, mem_rdata
   );
endinterface

// File: rtl/mem_access_sequencer.sv
// LC-3b MEM-stage access sequencer: issues one data-memory access for
// LDR/STR/LDB/STB and a read-then-access pointer chase for LDI/STI,
// stalling the pipeline until the final access completes.
// Optional feature: define MEM_TIMEOUT_EN to abandon an access after
// TIMEOUT_CYCLES cycles without mem_resp and raise the sticky mem_error.
module mem_access_sequencer
`ifdef MEM_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          valid,
   input  logic [3:0]                    opcode,
   input  logic [15:0]                   addr,
   input  logic [15:0]                   store_data,
   mem_access_sequencer_if.master        mem,
   output logic                          mem_stall,
   output logic [15:0]                   load_data,
   output logic                          mem_error
);

   localparam logic [3:0] OP_LDB = 4'b0010;
   localparam logic [3:0] OP_STB = 4'b0011;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;

   typedef enum logic [2:0] {IDLE, ACC1, GAP, ACC2, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] sdata_q, sdata_d;
   logic [15:0] ptr_q, ptr_d;
   logic        read_q, read_d;
   logic        write_q, write_d;
   logic [15:0] maddr_q, maddr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [1:0]  be_q, be_d;
   logic [15:0] load_q, load_d;
   logic        timeout_hit;

   function automatic logic is_mem_op(input logic [3:0] op);
      case (op)
         OP_LDR, OP_STR, OP_LDB, OP_STB, OP_LDI, OP_STI: is_mem_op = 1'b1;
         default:                                        is_mem_op = 1'b0;
      endcase
   endfunction

   // LDB returns the addressed byte sign-extended; word loads pass through.
   function automatic logic [15:0] load_format(input logic [3:0] op, input logic a0,
                                                input logic [15:0] rdata);
      logic [7:0] b;
      b = a0 ? rdata[15:8] : rdata[7:0];
      if (op == OP_LDB) load_format = {{8{b[7]}}, b};
      else              load_format = rdata;
   endfunction

   // Next-state, operand capture, load capture and request decode for the state being entered.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      sdata_d = sdata_q;
      ptr_d   = ptr_q;
      load_d  = load_q;

      case (state_q)
         IDLE: begin
            if (valid && is_mem_op(opcode)) begin
               state_d = ACC1;
               op_d    = opcode;
               addr_d  = addr;
               sdata_d = store_data;
            end
         end
         ACC1: begin
            if (mem.mem_resp) begin
               if (!valid) begin
                  state_d = IDLE;
               end else if (op_q == OP_LDI || op_q == OP_STI) begin
                  ptr_d   = mem.mem_rdata;
                  state_d = GAP;
               end else begin
                  state_d = DONE;
                  if (op_q == OP_LDR || op_q == OP_LDB)
                     load_d = load_format(op_q, addr_q[0], mem.mem_rdata);
               end
            end else if (timeout_hit) begin
               state_d = DONE;
            end
         end
         GAP: begin
            state_d = valid ? ACC2 : IDLE;
         end
         ACC2: begin
            if (mem.mem_resp) begin
               if (!valid) begin
                  state_d = IDLE;
               end else begin
                  state_d = DONE;
                  if (op_q == OP_LDI) load_d = mem.mem_rdata;
               end
            end else if (timeout_hit) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Requests are registered, so they are decoded from the next state and
      // the operands as they will be latched on this edge.
      read_d  = 1'b0;
      write_d = 1'b0;
      maddr_d = 16'h0000;
      wdata_d = 16'h0000;
      be_d    = 2'b00;
      if (state_d == ACC1) begin
         maddr_d = {addr_d[15:1], 1'b0};
         if (op_d == OP_STR || op_d == OP_STB) write_d = 1'b1;
         else                                  read_d  = 1'b1;
      end else if (state_d == ACC2) begin
         maddr_d = {ptr_d[15:1], 1'b0};
         if (op_d == OP_STI) write_d = 1'b1;
         else                read_d  = 1'b1;
      end
      if (write_d) begin
         if (op_d == OP_STB) begin
            wdata_d = {sdata_d[7:0], sdata_d[7:0]};
            be_d    = addr_d[0] ? 2'b10 : 2'b01;
         end else begin
            wdata_d = sdata_d;
            be_d    = 2'b11;
         end
      end
   end

   // FSM state, pointer, registered bus outputs and load result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= 16'h0000;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         maddr_q <= 16'h0000;
         wdata_q <= 16'h0000;
         be_q    <= 2'b00;
         load_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         read_q  <= read_d;
         write_q <= write_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         load_q  <= load_d;
      end
   end

   // Instruction operands latched at the start of an access; they need no reset.
   always_ff @(posedge clk) begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // Wait counter sits at zero outside ACC1/ACC2, so it is clear on every entry.
   always_comb begin
      cnt_d       = '0;
      err_d       = err_q;
      timeout_hit = 1'b0;
      if ((state_q == ACC1 || state_q == ACC2) && !mem.mem_resp) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) begin
            timeout_hit = 1'b1;
            err_d       = 1'b1;
         end
      end
   end

   // Timeout counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign mem_error = err_q;
`else
   assign timeout_hit = 1'b0;
   assign mem_error   = 1'b0;
`endif

   assign mem.mem_read        = read_q;
   assign mem.mem_write       = write_q;
   assign mem.mem_address     = maddr_q;
   assign mem.mem_wdata       = wdata_q;
   assign mem.mem_byte_enable = be_q;
   assign load_data           = load_q;
   assign mem_stall           = valid & is_mem_op(opcode) & (state_q != DONE);

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer; the memory side is driven by hand
// cycle by cycle. Timeout checks are built only with MEM_TIMEOUT_EN.
module tb_mem_access_sequencer;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LDB = 4'b0010;
   localparam logic [3:0] OP_STB = 4'b0011;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_LDI = 4'b1010;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic [3:0]  opcode;
   logic [15:0] addr;
   logic [15:0] store_data;
   logic        mem_stall;
   logic [15:0] load_data;
   logic        mem_error;

   int n_cmp = 0;
   int n_bad = 0;

   mem_access_sequencer_if bus ();

`ifdef MEM_TIMEOUT_EN
   mem_access_sequencer #(.TIMEOUT_CYCLES(4)) dut (
`else
   mem_access_sequencer dut (
`endif
      .clk        (clk),
      .reset      (reset),
      .valid      (valid),
      .opcode     (opcode),
      .addr       (addr),
      .store_data (store_data),
      .mem        (bus),
      .mem_stall  (mem_stall),
      .load_data  (load_data),
      .mem_error  (mem_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Zero-wait single read; checks the request and the formatted load result.
   task automatic zero_wait_read(input string tag, input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] rd, input logic [15:0] exp_load);
      tick();
      valid = 1'b1; opcode = op; addr = a; #1;
      chk({tag, "_stall_c0"}, mem_stall, 1);
      tick();
      bus.mem_resp = 1'b1; bus.mem_rdata = rd; #1;
      chk({tag, "_read_c1"}, bus.mem_read, 1);
      chk({tag, "_addr_c1"}, bus.mem_address, {a[15:1], 1'b0});
      tick();
      bus.mem_resp = 1'b0; #1;
      chk({tag, "_stall_done"}, mem_stall, 0);
      chk({tag, "_load"}, load_data, exp_load);
      tick();
      valid = 1'b0; #1;
   endtask

   initial begin
      reset = 1'b1; valid = 1'b0; opcode = 4'h0; addr = 16'h0; store_data = 16'h0;
      bus.mem_resp = 1'b0; bus.mem_rdata = 16'h0;
      tick(); tick();
      reset = 1'b0; #1;
      chk("rst_read", bus.mem_read, 0);
      chk("rst_write", bus.mem_write, 0);
      chk("rst_addr", bus.mem_address, 16'h0000);
      chk("rst_wdata", bus.mem_wdata, 16'h0000);
      chk("rst_be", bus.mem_byte_enable, 2'b00);
      chk("rst_load", load_data, 16'h0000);
      chk("rst_err", mem_error, 0);
      chk("rst_stall", mem_stall, 0);

      // Non-memory op: no stall, no request
      tick();
      valid = 1'b1; opcode = OP_ADD; addr = 16'h1234; #1;
      chk("add_stall", mem_stall, 0);
      tick();
      valid = 1'b0; #1;
      chk("add_read", bus.mem_read, 0);
      chk("add_write", bus.mem_write, 0);

      // LDR 0x1003 with two wait cycles, rdata 0xBEEF
      tick();
      valid = 1'b1; opcode = OP_LDR; addr = 16'h1003; #1;
      chk("ldr_stall_c0", mem_stall, 1);
      chk("ldr_read_c0", bus.mem_read, 0);
      tick(); #1;
      chk("ldr_read_c1", bus.mem_read, 1);
      chk("ldr_addr_c1", bus.mem_address, 16'h1002);
      chk("ldr_be_c1", bus.mem_byte_enable, 2'b00);
      chk("ldr_stall_c1", mem_stall, 1);
      tick(); #1;
      chk("ldr_read_c2", bus.mem_read, 1);
      tick();
      bus.mem_resp = 1'b1; bus.mem_rdata = 16'hBEEF; #1;
      chk("ldr_read_c3", bus.mem_read, 1);
      chk("ldr_stall_c3", mem_stall, 1);
      tick();
      bus.mem_resp = 1'b0; #1;
      chk("ldr_read_done", bus.mem_read, 0);
      chk("ldr_stall_done", mem_stall, 0);
      chk("ldr_load", load_data, 16'hBEEF);
      tick();
      valid = 1'b0; #1;

      // STB 0x12A5 at 0x2001: high byte lane, data replicated
      tick();
      valid = 1'b1; opcode = OP_STB; addr = 16'h2001; store_data = 16'h12A5; #1;
      chk("stb_stall_c0", mem_stall, 1);
      tick();
      bus.mem_resp = 1'b1; #1;
      chk("stb_write", bus.mem_write, 1);
      chk("stb_read", bus.mem_read, 0);
      chk("stb_addr", bus.mem_address, 16'h2000);
      chk("stb_wdata", bus.mem_wdata, 16'hA5A5);
      chk("stb_be", bus.mem_byte_enable, 2'b10);
      tick();
      bus.mem_resp = 1'b0; #1;
      chk("stb_write_done", bus.mem_write, 0);
      chk("stb_stall_done", mem_stall, 0);
      chk("stb_load_kept", load_data, 16'hBEEF);
      tick();
      valid = 1'b0; #1;

      // LDB sign extension, low then high byte
      zero_wait_read("ldb_lo", OP_LDB, 16'h3000, 16'h7F80, 16'hFF80);
      zero_wait_read("ldb_hi", OP_LDB, 16'h3001, 16'h7F80, 16'h007F);

      // STI 0x4000 -> pointer 0x5006; inputs change mid-op and must be ignored
      tick();
      valid = 1'b1; opcode = OP_STI; addr = 16'h4000; store_data = 16'h1357; #1;
      chk("sti_stall_c0", mem_stall, 1);
      tick();
      bus.mem_resp = 1'b1; bus.mem_rdata = 16'h5006; #1;
      chk("sti_acc1_read", bus.mem_read, 1);
      chk("sti_acc1_write", bus.mem_write, 0);
      chk("sti_acc1_addr", bus.mem_address, 16'h4000);
      tick();
      bus.mem_resp = 1'b0; addr = 16'hFFFF; store_data = 16'h0000; #1;
      chk("sti_gap_read", bus.mem_read, 0);
      chk("sti_gap_write", bus.mem_write, 0);
      chk("sti_gap_stall", mem_stall, 1);
      tick();
      bus.mem_resp = 1'b1; #1;
      chk("sti_acc2_write", bus.mem_write, 1);
      chk("sti_acc2_read", bus.mem_read, 0);
      chk("sti_acc2_addr", bus.mem_address, 16'h5006);
      chk("sti_acc2_wdata", bus.mem_wdata, 16'h1357);
      chk("sti_acc2_be", bus.mem_byte_enable, 2'b11);
      chk("sti_acc2_stall", mem_stall, 1);
      tick();
      bus.mem_resp = 1'b0; #1;
      chk("sti_done_stall", mem_stall, 0);
      chk("sti_done_write", bus.mem_write, 0);
      chk("sti_load_kept", load_data, 16'h007F);
      tick();
      valid = 1'b0; #1;

      // LDI full chase 0x8000 -> 0x8100 -> 0xCAFE
      tick();
      valid = 1'b1; opcode = OP_LDI; addr = 16'h8000; #1;
      tick();
      bus.mem_resp = 1'b1; bus.mem_rdata = 16'h8100; #1;
      chk("ldi_acc1_addr", bus.mem_address, 16'h8000);
      tick();
      bus.mem_resp = 1'b0; #1;
      chk("ldi_gap_read", bus.mem_read, 0);
      tick();
      bus.mem_resp = 1'b1; bus.mem_rdata = 16'hCAFE; #1;
      chk("ldi_acc2_read", bus.mem_read, 1);
      chk("ldi_acc2_addr", bus.mem_address, 16'h8100);
      tick();
      bus.mem_resp = 1'b0; #1;
      chk("ldi_done_stall", mem_stall, 0);
      chk("ldi_load", load_data, 16'hCAFE);
      tick();
      valid = 1'b0; #1;

      // LDI flushed in ACC1: first read completes, no second access, load kept
      tick();
      valid = 1'b1; opcode = OP_LDI; addr = 16'h6000; #1;
      tick();
      valid = 1'b0; bus.mem_resp = 1'b1; bus.mem_rdata = 16'h1234; #1;
      chk("flush1_read", bus.mem_read, 1);
      chk("flush1_stall", mem_stall, 0);
      tick();
      bus.mem_resp = 1'b1; bus.mem_rdata = 16'h5555; #1;
      chk("flush1_idle_read", bus.mem_read, 0);
      tick();
      bus.mem_resp = 1'b0; #1;
      chk("flush1_no_acc2_read", bus.mem_read, 0);
      chk("flush1_no_acc2_write", bus.mem_write, 0);
      chk("flush1_load_kept", load_data, 16'hCAFE);

      // LDI flushed in GAP: no ACC2 issued
      tick();
      valid = 1'b1; opcode = OP_LDI; addr = 16'h7000; #1;
      tick();
      bus.mem_resp = 1'b1; bus.mem_rdata = 16'h7100; #1;
      tick();
      bus.mem_resp = 1'b0; valid = 1'b0; #1;
      tick(); #1;
      chk("flushgap_read", bus.mem_read, 0);
      chk("flushgap_addr", bus.mem_address, 16'h0000);

      // Reset during ACC2 with a pending response
      tick();
      valid = 1'b1; opcode = OP_LDI; addr = 16'h9000; #1;
      tick();
      bus.mem_resp = 1'b1; bus.mem_rdata = 16'h9100; #1;
      tick();
      bus.mem_resp = 1'b0; #1;
      tick();
      reset = 1'b1; bus.mem_resp = 1'b1; bus.mem_rdata = 16'hDEAD; #1;
      chk("rst2_acc2_read", bus.mem_read, 1);
      tick();
      reset = 1'b0; valid = 1'b0; bus.mem_resp = 1'b0; #1;
      chk("rst2_read", bus.mem_read, 0);
      chk("rst2_write", bus.mem_write, 0);
      chk("rst2_addr", bus.mem_address, 16'h0000);
      chk("rst2_be", bus.mem_byte_enable, 2'b00);
      chk("rst2_load", load_data, 16'h0000);
      tick(); #1;
      chk("rst2_idle_read", bus.mem_read, 0);

`ifdef MEM_TIMEOUT_EN
      // Memory never answers: four request cycles, then error and DONE
      tick();
      valid = 1'b1; opcode = OP_LDR; addr = 16'hA000; #1;
      for (int i = 1; i <= 4; i++) begin
         tick(); #1;
         chk("to_read_wait", bus.mem_read, 1);
         chk("to_err_wait", mem_error, 0);
      end
      tick(); #1;
      chk("to_read_dropped", bus.mem_read, 0);
      chk("to_err_set", mem_error, 1);
      chk("to_stall_done", mem_stall, 0);
      chk("to_load_kept", load_data, 16'h0000);
      tick();
      valid = 1'b0; #1;
      tick(); #1;
      chk("to_err_sticky", mem_error, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0; #1;
      chk("to_err_cleared", mem_error, 0);
`else
      chk("no_timeout_err", mem_error, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Memory-stage access sequencer for the LC-3b pipeline: turns the MEM-stage instruction (opcode, effective address, store data) into one or two handshaked data-memory transactions. Handles word/byte alignment for LDR/STR/LDB/STB and the two-access pointer chase for LDI/STI. Holds the pipeline with `mem_stall` until the final access completes. Sits between the EX/MEM pipeline register and the data-memory port; its `load_data` feeds the MEM/WB register.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles without `mem_resp` before an access is abandoned (used only with the timeout feature compiled in)
- `clk` in 1: clock; all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `valid` in 1: MEM-stage instruction is valid
- `opcode` in 4: `lc3b_opcode` of MEM-stage instruction
- `addr` in 16: effective address from EX
- `store_data` in 16: SR value for stores
- `mem_resp` in 1: memory completed current request this cycle
- `mem_rdata` in 16: read data, valid with `mem_resp`
- `mem_read` out 1: read request
- `mem_write` out 1: write request
- `mem_address` out 16: word-aligned request address
- `mem_wdata` out 16: write data
- `mem_byte_enable` out 2: write byte lanes, bit1 = high byte
- `mem_stall` out 1: hold pipeline upstream of and including MEM
- `load_data` out 16: registered load result for MEM/WB
- `mem_error` out 1: sticky timeout flag

## Operation
- Memory ops: `op_ldr`, `op_str`, `op_ldb`, `op_stb`, `op_ldi`, `op_sti`; all other opcodes pass through with no request and no stall.
- FSM states: IDLE, ACC1, GAP, ACC2, DONE.
- IDLE: no request. If `valid` and memory op, go to ACC1. Otherwise stay in IDLE.
- ACC1: request at `{addr[15:1],1'b0}`.
  - Read for LDR/LDB/LDI/STI; write for STR/STB.
  - On `mem_resp`: LDI/STI latch `mem_rdata` into pointer register and go to GAP. Other ops go to DONE.
- GAP: one cycle with both requests low, then go to ACC2. This guarantees a deassert between back-to-back transactions.
- ACC2: request at `{pointer[15:1],1'b0}`; read for LDI, write for STI. On `mem_resp`, go to DONE.
- DONE: one cycle, no request, then go to IDLE.
- Requests are decoded from registered state plus the latched opcode/address only. Opcode, addr and store_data are captured on IDLE→ACC1 and are immune to input changes mid-op.
- Write data:
  - STR/STI: `mem_wdata = store_data`, byte enable `11`.
  - STB: `mem_wdata = {store_data[7:0], store_data[7:0]}`, byte enable `01` if `addr[0]=0`, else `10`.
  - Byte enable is `00` on reads.
- `load_data` is captured on the final read `mem_resp`:
  - LDR/LDI: full word.
  - LDB: selected byte (`addr[0]` picks high byte) sign-extended to 16 bits.
  - Held until the next capture.
- `mem_stall = valid & memory_op & (state != DONE)`. It is low in DONE, so the pipeline advances on that edge.
- Flush: if `valid` drops in ACC1 or ACC2, the outstanding access still completes (no abort). On `mem_resp` the FSM goes to IDLE, not DONE, and `load_data` is not updated. If `valid` drops in GAP, go to IDLE without issuing ACC2.

## Timing
- Reset values:
  - state IDLE
  - `mem_read`/`mem_write` 0
  - `mem_address`/`mem_wdata` 0
  - `mem_byte_enable` 00
  - `load_data` 0
  - `mem_error` 0
  - pointer 0
- Reset mid-op forces IDLE on that edge; requests are low the next cycle. A pending `mem_resp` during reset is ignored.
- Latency with zero-wait memory (resp in the first cycle of the request), counted from the first valid cycle in IDLE:
  - single-access op: stall cycles 0–1, low in cycle 2 (DONE)
  - LDI/STI: ACC1 in cycle 1, GAP in cycle 2, ACC2 in cycle 3, DONE in cycle 4
- Each wait cycle on `mem_resp` adds one cycle.
- `mem_resp` outside ACC1/ACC2 is ignored.

## Configuration
- `MEM_TIMEOUT_EN` defined: an 8+-bit counter clears on entry to ACC1/ACC2 and increments each cycle without `mem_resp`.
  - When it reaches `TIMEOUT_CYCLES`, set `mem_error` (sticky until reset), drop requests, and go to DONE.
  - `load_data` is unchanged on timeout.
- Undefined: no counter; `mem_error` tied 0; the FSM waits indefinitely for `mem_resp`.

## Test plan
- LDR at addr 0x1003, memory returns 0xBEEF after 2 wait cycles → `mem_address` 0x1002, `mem_read` high for 3 cycles, stall released one cycle later, `load_data` 0xBEEF.
- STB store_data 0x12A5 at addr 0x2001 → `mem_wdata` 0xA5A5, byte enable `10`, `mem_write` 1, no `load_data` change.
- LDB addr 0x3000, rdata 0x7F80 → `load_data` 0xFF80. Then addr 0x3001, same rdata → 0x007F.
- STI addr 0x4000, first read returns 0x5006 → GAP cycle with both requests low, then write 0x5006 with `store_data`, byte enable `11`, stall low exactly at DONE.
- LDI with `valid` dropped during ACC1 → first read completes, no ACC2, FSM back to IDLE, `load_data` unchanged. Separately, `reset` asserted in ACC2 → all outputs at reset values next cycle.
- `MEM_TIMEOUT_EN` with `TIMEOUT_CYCLES`=4, memory never responds → `mem_error` rises after 4 request cycles, requests drop, stays 1 until `reset`.
